// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full_adder LSB-first.
// Define SERIAL_ADDER_SUB_EN to add a sub port that makes the block compute a - b.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);
   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] sh_a, sh_b, acc, b_ld;
   logic [CW-1:0] cnt;
   logic carry, c_ld, fa_s, fa_c, last;
`ifdef SERIAL_ADDER_SUB_EN
   // two's complement subtract: invert b and force the initial carry
   assign b_ld = sub ? ~b : b;
   assign c_ld = sub | c_in;
`else
   assign b_ld = b;
   assign c_ld = c_in;
`endif
   assign last = cnt == CW'(WIDTH - 1);
   full_adder u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .c_in (carry),
      .s    (fa_s),
      .c_out(fa_c)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      state_nxt = state == IDLE ? (start ? ADD : IDLE) :
                  state == ADD  ? (last ? DONE : ADD) : IDLE;
      busy      = state == ADD;
      done      = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a  <= '0;
         sh_b  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            sh_a  <= a;
            sh_b  <= b_ld;
            carry <= c_ld;
            cnt   <= '0;
         end
      end else if (state == ADD) begin
         sh_a  <= sh_a >> 1;
         sh_b  <= sh_b >> 1;
         acc   <= {fa_s, acc[WIDTH-1:1]};
         carry <= fa_c;
         cnt   <= cnt + CW'(1);
         // result ports only move on the completing edge
         if (last) begin
            sum   <= {fa_s, acc[WIDTH-1:1]};
            c_out <= fa_c;
         end
      end
   end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller that sequences a single `full_adder` instance, one bit per clock, to add two WIDTH-bit operands.
- Latches operands on a start request, shifts LSB-first through the `full_adder`, and keeps the carry in a flip-flop between bits.
- Presents the registered result with a one-cycle done pulse.
- Sits between lab-level control logic and the shared 1-bit adder datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk      input   1      system clock, rising-edge active
rst_n    input   1      asynchronous active-low reset
start    input   1      request a new addition; sampled only in IDLE
a        input   WIDTH  operand A, sampled on the accepting edge
b        input   WIDTH  operand B, sampled on the accepting edge
c_in     input   1      initial carry-in, sampled on the accepting edge
busy     output  1      high while in ADD state
done     output  1      one-cycle pulse: sum/c_out just updated
sum      output  WIDTH  registered result; holds until next completion
c_out    output  1      registered final carry; holds until next completion

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, sum = 0, c_out = 0.
  - Shift registers, carry flop and bit counter cleared.
- Deassertion of rst_n takes effect on the next rising edge.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On an edge with start = 1: load sh_a <= a, sh_b <= b, carry <= c_in, cnt <= 0, go to ADD.
  - Otherwise stay in IDLE.
- ADD (busy = 1):
  - The `full_adder` instance is driven with a = sh_a[0], b = sh_b[0], c_in = carry.
  - Each edge:
    - sh_a and sh_b shift right by 1, zero-filled.
    - The adder's sum bit shifts into the MSB of the internal result register acc.
    - carry <= adder c_out.
    - cnt <= cnt + 1.
  - On the edge where cnt == WIDTH-1:
    - sum <= final acc, including the bit computed on this edge.
    - c_out <= adder c_out.
    - go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - Next edge returns unconditionally to IDLE.
- Latency:
  - Request accepted on edge k.
  - Bits processed on edges k+1 .. k+WIDTH.
  - done is high in the cycle following edge k+WIDTH.
  - A new request is accepted no earlier than edge k+WIDTH+2.
- start is ignored while in ADD or DONE. Operand changes during ADD do not affect the result in flight.
- sum and c_out change only on the completing edge; intermediate shift values are never visible on the ports.
- cnt is $clog2(WIDTH) bits wide; it does not wrap within a transfer.
- Reset mid-operation:
  - Aborts immediately; all outputs return to reset values.
  - No done pulse is generated for the aborted transfer.
- start held high continuously: a new addition begins each time IDLE is re-entered, so one result every WIDTH+2 cycles.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port `sub` (1 bit), sampled with the operands on the accepting edge.
  - When sub = 1: sh_b loads ~b, carry loads 1 (c_in is ignored).
  - The result is A - B in two's complement; c_out = 1 means no borrow.
  - When sub = 0: behaviour is identical to the base block.
- Not defined:
  - No `sub` port; addition only, exactly as in Behaviour.

Test Plan:
1. WIDTH=8; reset, then start with a=0x5A, b=0x3C, c_in=0 -> busy high for 8 cycles; done pulses once; sum=0x96, c_out=0.
2. a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
3. start pulsed again 3 cycles into ADD, with a/b changed to 0x00 -> ignored; result is from the original operands; exactly one done pulse.
4. rst_n asserted 4 cycles into ADD -> busy/done/sum/c_out go to 0 immediately, before the next edge; no done pulse after release; a subsequent 0x01+0x02 gives 0x03.
5. start held high for 30 cycles, a=0x10, b=0x20 -> a done pulse every 10 cycles; sum=0x30 each time.
6. (SERIAL_ADDER_SUB_EN) sub=1, a=0x10, b=0x01 -> sum=0x0F, c_out=1. Then sub=1, a=0x01, b=0x02 -> sum=0xFF, c_out=0.
